// File: rtl/param_updown_counter.sv
// Parametrised up/down/ping-pong counter with a programmable modulo limit,
// wrap-or-saturate behaviour, synchronous load, a prescaler and a one-cycle
// terminal-count pulse. The count only moves on "advance" edges, which happen
// once every div+1 enabled cycles.
module param_updown_counter #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic [PSC_W-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc
);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [PSC_W-1:0] psc;
    logic             advance;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] max_m1;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] nxt_count;
    logic             nxt_dir;
    logic             nxt_tc;

    // The prescaler wraps through 2^PSC_W if div is lowered below it, so only
    // exact equality triggers an advance.
    assign advance      = en && (psc == div);
    assign inc          = count + ONE;
    assign dec          = count - ONE;
    assign max_m1       = max_val - ONE;
    assign load_clamped = (load_val > max_val) ? max_val : load_val;

    // Next count/dir/tc assuming this edge is an advance edge.
    always_comb begin
        nxt_count = count;
        nxt_dir   = dir;
        nxt_tc    = 1'b0;
        case (mode)
            MODE_UP: begin
                if (count < max_val) begin
                    nxt_count = inc;
                    nxt_tc    = sat && (inc == max_val);
                end else if (!sat) begin
                    nxt_count = ZERO;
                    nxt_tc    = 1'b1;
                end else begin
                    nxt_count = max_val;
                end
            end
            MODE_DOWN: begin
                if (count > max_val) begin
                    nxt_count = max_val;
                end else if (count != ZERO) begin
                    nxt_count = dec;
                    nxt_tc    = sat && (dec == ZERO);
                end else if (!sat) begin
                    nxt_count = max_val;
                    nxt_tc    = 1'b1;
                end
            end
            MODE_PING: begin
                // A zero-length range would otherwise bounce to max_val-1
                // (all ones); pin it at 0 and just flip direction.
                if (max_val == ZERO) begin
                    nxt_count = ZERO;
                    nxt_dir   = ~dir;
                    nxt_tc    = 1'b1;
                end else if (!dir) begin
                    if (count < max_val) begin
                        nxt_count = inc;
                    end else begin
                        nxt_count = max_m1;
                        nxt_dir   = 1'b1;
                        nxt_tc    = 1'b1;
                    end
                end else begin
                    if (count > max_val) begin
                        nxt_count = max_val;
                    end else if (count != ZERO) begin
                        nxt_count = dec;
                    end else begin
                        nxt_count = ONE;
                        nxt_dir   = 1'b0;
                        nxt_tc    = 1'b1;
                    end
                end
            end
            default: begin
                nxt_count = count;
            end
        endcase
    end

    // Register update: reset beats load, load beats the prescaler/advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= ZERO;
            dir   <= 1'b0;
            tc    <= 1'b0;
            psc   <= '0;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
            psc   <= '0;
        end else if (advance) begin
            count <= nxt_count;
            dir   <= nxt_dir;
            tc    <= nxt_tc;
            psc   <= '0;
        end else begin
            tc <= 1'b0;
            if (en) begin
                psc <= psc + 1'b1;
            end
        end
    end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the fixed free-running counter.
- Adds selectable width, programmable modulo limit, up/down/ping-pong/hold modes, wrap-or-saturate, synchronous load, a programmable prescaler and a terminal-count pulse.
- Sits behind the top-level IO wrapper; ui_in/uio_in drive its controls and uo_out shows count.

Parameters:
WIDTH, 8, counter width in bits
PSC_W, 8, prescaler divider width in bits

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
en  input  1  count enable; gates the prescaler and advances
mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold
sat  input  1  1 = saturate at limits, 0 = wrap; ignored in ping-pong
load  input  1  synchronous load strobe
load_val  input  WIDTH  value to load
max_val  input  WIDTH  upper bound; count range is 0..max_val
div  input  PSC_W  advance every div+1 enabled cycles
count  output  WIDTH  registered count
dir  output  1  registered direction: 0 up, 1 down (ping-pong state)
tc  output  1  registered one-cycle terminal-count pulse

Behaviour:
- Reset (rst=1 at a clk edge): count=0, dir=0, tc=0, prescaler=0. Reset mid-operation overrides everything on that edge.
- Priority per edge: rst > load > advance.
- load=1: count <= min(load_val, max_val); prescaler <= 0; tc <= 0; dir unchanged. Load works regardless of en.
- Prescaler psc (PSC_W bits):
  - When en=1 and psc!=div: psc <= psc+1, no advance.
  - When en=1 and psc==div: psc <= 0 and an advance occurs this edge.
  - en=0 freezes psc and count.
  - div=0 gives an advance every enabled cycle.
  - If div is lowered below the current psc, the next advance occurs after psc wraps through 2^PSC_W.
- tc is 0 on every edge without an advance. On an advance edge, tc is set per the rules below.
- Advance, mode up:
  - count < max_val: count+1. With sat=1, tc=1 iff the new count == max_val.
  - count >= max_val, sat=0: count <= 0, tc=1.
  - count >= max_val, sat=1: count <= max_val, tc=0.
- Advance, mode down:
  - count > max_val: count <= max_val, tc=0.
  - 0 < count <= max_val: count-1. With sat=1, tc=1 iff the new count == 0.
  - count == 0, sat=0: count <= max_val, tc=1.
  - count == 0, sat=1: hold 0, tc=0.
- Advance, mode ping-pong:
  - dir=0 and count < max_val: count+1.
  - dir=0 and count >= max_val: count <= max_val-1, dir <= 1, tc=1.
  - dir=1 and count > max_val: count <= max_val, tc=0.
  - dir=1 and 0 < count <= max_val: count-1.
  - dir=1 and count == 0: count <= 1, dir <= 0, tc=1.
  - max_val=0: count stays 0, tc=1 on every advance, dir toggles.
- Advance, mode hold: count and dir unchanged, tc=0. The prescaler still runs.
- dir changes only in ping-pong. Entering ping-pong resumes with the stored dir.
- Mode, sat and max_val changes take effect at the next advance.
- Latency: count, dir and tc all update on the same edge as the advance and are visible one cycle after the edge.
- Arithmetic is unsigned, WIDTH bits, with no overflow beyond the rules above. max_val = 2^WIDTH-1 gives a full-range counter.

Test Plan:
- Reset then up-wrap: rst 2 cycles, WIDTH=8, max_val=5, div=0, mode=up, sat=0, en=1 -> count 0,1,2,3,4,5,0,1; tc high only on the cycle count shows 0 after 5.
- Saturate down: load load_val=3, mode=down, sat=1 -> count 2,1,0,0,0; tc high only when count first shows 0.
- Ping-pong: max_val=3 from count 0 -> count 1,2,3,2,1,0,1; dir 0→1 when count shows 2 after 3, 1→0 when count shows 1 after 0; tc on those two cycles.
- Prescaler and enable: div=2, mode=up -> count increments every 3rd cycle. en low for 4 cycles mid-count -> count and psc frozen, resume from the same phase.
- Load priority and clamp: load=1 with load_val=200, max_val=9 on an advance cycle -> count=9, tc=0, psc=0. rst=1 together with load -> count=0.
- Edge cases: max_val=0 in ping-pong -> count 0 and tc high every advance. Lowering max_val below count in down mode -> count clamps to max_val on the next advance.
